tone_sequencer: RTL

Plays a fixed eight-note melody (C4 to C5 major scale) as a square wave toward the audio codec interface. It is the initiator of the tone-duration handshake: it issues `tone_start` for each note and advances when the one-second duration timer answers with `tone_done`. It sits between the user controls (`play`, `stop`) and the codec sample path, supplying one sample per `sample_req`.

---
 rtl/tone_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// Eight-note (C4..C5) square-wave melody player. Each note is started with a
// tone_start pulse toward the duration timer and ends on its tone_done reply.
// One sample is produced for every sample_req, in every state.
module tone_sequencer #(
    parameter int                  SAMPLE_W  = 16,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE = 16'h2000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                play,
    input  logic                stop,
    input  logic                sample_req,
    input  logic                tone_done,
    output logic                tone_start,
    output logic [2:0]          note_idx,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                seq_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_PLAY,
        S_FINISH
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          note_q, note_d;
    logic [6:0]          phase_q, phase_d;
    logic                pol_q, pol_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sample_valid_q;
    logic                tone_start_q;
    logic                busy_q;
    logic                seq_done_q;
    logic [6:0]          half_per;

    // Half-period of each note, in sample_req ticks (48 kHz sample rate).
    function automatic logic [6:0] note_half_period(input logic [2:0] idx);
        logic [6:0] hp;
        case (idx)
            3'd0:    hp = 7'd92;
            3'd1:    hp = 7'd82;
            3'd2:    hp = 7'd73;
            3'd3:    hp = 7'd69;
            3'd4:    hp = 7'd61;
            3'd5:    hp = 7'd55;
            3'd6:    hp = 7'd49;
            default: hp = 7'd46;
        endcase
        return hp;
    endfunction

    assign half_per = note_half_period(note_q);

    // Next-state and note index; stop overrides every other transition.
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        case (state_q)
            S_IDLE: begin
                if (play) begin
                    state_d = S_START;
                    note_d  = 3'd0;
                end
            end
            S_START: state_d = S_PLAY;
            S_PLAY: begin
                if (tone_done) begin
                    if (note_q == 3'd7) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_START;
                        note_d  = note_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                note_d  = 3'd0;
            end
        endcase
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            note_d  = 3'd0;
        end
    end

    // Square-wave phase and sample value. The sample uses the phase as it
    // stands this cycle, so a coincident tone_done still gets the old note.
    always_comb begin
        phase_d  = phase_q;
        pol_d    = pol_q;
        sample_d = sample_q;
        if (state_q == S_START) begin
            phase_d = 7'd0;
            pol_d   = 1'b1;
        end
        if (sample_req) begin
            if (state_q == S_PLAY) begin
                sample_d = pol_q ? AMPLITUDE : ('0 - AMPLITUDE);
                if (phase_q == half_per - 7'd1) begin
                    phase_d = 7'd0;
                    pol_d   = ~pol_q;
                end else begin
                    phase_d = phase_q + 7'd1;
                end
            end else begin
                sample_d = '0;
            end
        end else if (state_d == S_IDLE) begin
            // Idle output reads zero once no sample is pending.
            sample_d = '0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= S_IDLE;
            note_q         <= 3'd0;
            phase_q        <= 7'd0;
            pol_q          <= 1'b1;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            tone_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            seq_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            note_q         <= note_d;
            phase_q        <= phase_d;
            pol_q          <= pol_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_req;
            tone_start_q   <= (state_d == S_START);
            busy_q         <= (state_d != S_IDLE);
            seq_done_q     <= (state_d == S_FINISH);
        end
    end

    assign tone_start   = tone_start_q;
    assign note_idx     = note_q;
    assign sample_out   = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign seq_done     = seq_done_q;

endmodule
